// File: rtl/lcd_char_pkg.sv
// Shared types and defaults for the LCD character glyph fetcher.
package lcd_char_pkg;

  localparam int unsigned DEF_GLYPH_BYTES = 32;
  localparam int unsigned DEF_ADDR_W      = 5;
  localparam int unsigned LCD_PAGES       = 8;
  localparam int unsigned LCD_COLS        = 128;
  localparam int unsigned PAGE_W          = 3;
  localparam int unsigned COL_W           = 7;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StCap,
    StPush,
    StDone
  } fetch_state_e;

endpackage

// File: rtl/lcd_char_fetch_if.sv
// ROM-combiner and LCD-write-stage signals of one character block.
// master = fetcher side, slave = ROM combiner / LCD write stage side.
interface lcd_char_fetch_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              char_ready;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              lcd_valid;
  logic              lcd_ready;
  logic [7:0]        lcd_data;
  logic [2:0]        lcd_page;
  logic [6:0]        lcd_col;

  modport master (
    output char_ready, rom_addr, lcd_valid, lcd_data, lcd_page, lcd_col,
    input  rom_data, lcd_ready
  );

  modport slave (
    input  char_ready, rom_addr, lcd_valid, lcd_data, lcd_page, lcd_col,
    output rom_data, lcd_ready
  );
endinterface

// File: rtl/lcd_char_pos.sv
// Maps a glyph byte index plus the latched bases onto an LCD page/column.
// Top half of the glyph lands on page_base, bottom half on page_base+1; both wrap.
module lcd_char_pos
  import lcd_char_pkg::*;
#(
  parameter int unsigned GLYPH_BYTES = DEF_GLYPH_BYTES,
  parameter int unsigned ADDR_W      = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] idx,
  input  logic [PAGE_W-1:0] page_base,
  input  logic [COL_W-1:0]  col_base,
  output logic [PAGE_W-1:0] page,
  output logic [COL_W-1:0]  col
);

  localparam logic [ADDR_W-1:0] Half = ADDR_W'(GLYPH_BYTES / 2);

  logic              lower;
  logic [ADDR_W-1:0] col_off;

  // idx never exceeds GLYPH_BYTES-1, so one subtraction replaces the modulo
  always_comb begin
    lower   = (idx >= Half);
    col_off = lower ? (idx - Half) : idx;
    page    = page_base + PAGE_W'(lower);
    col     = col_base + COL_W'(col_off);
  end

endmodule

// File: rtl/lcd_char_fetch.sv
// Requester side of the glyph ROM-sharing interface: walks one 32-byte glyph through
// the ROM combiner and pushes each byte, tagged with page/column, to the LCD write stage.
// Optional feature: define LCD_CHAR_INVERT_EN to add the invert input (highlighted cell).
module lcd_char_fetch
  import lcd_char_pkg::*;
#(
  parameter int unsigned GLYPH_BYTES = DEF_GLYPH_BYTES,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned ROM_LAT     = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [PAGE_W-1:0] page_base,
  input  logic [COL_W-1:0]  col_base,
`ifdef LCD_CHAR_INVERT_EN
  input  logic              invert,
`endif
  output logic              busy,
  output logic              done,
  lcd_char_fetch_if.master  bus
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(GLYPH_BYTES - 1);
  localparam logic [1:0]        LatLast = 2'((ROM_LAT == 0) ? 0 : ROM_LAT - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        wait_q, wait_d;
  logic [PAGE_W-1:0] page_base_q;
  logic [COL_W-1:0]  col_base_q;
  logic              accept;
  logic              capture;
  logic [7:0]        cap_data;
  logic [PAGE_W-1:0] pos_page;
  logic [COL_W-1:0]  pos_col;
  logic [7:0]        data_q;
  logic [PAGE_W-1:0] page_q;
  logic [COL_W-1:0]  col_q;
  logic              valid_q;
`ifdef LCD_CHAR_INVERT_EN
  logic              invert_q;
`endif

  lcd_char_pos #(
    .GLYPH_BYTES(GLYPH_BYTES),
    .ADDR_W     (ADDR_W)
  ) u_pos (
    .idx      (idx_q),
    .page_base(page_base_q),
    .col_base (col_base_q),
    .page     (pos_page),
    .col      (pos_col)
  );

  // State, byte index and ROM wait counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      idx_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic; the wait counter runs only in REQ
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          idx_d   = '0;
          wait_d  = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (wait_q == LatLast) begin
          wait_d  = '0;
          state_d = StCap;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      StCap: begin
        capture = 1'b1;
        state_d = StPush;
      end
      StPush: begin
        if (bus.lcd_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            wait_d  = '0;
            state_d = StReq;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Glyph position and style are latched once per accepted start
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      page_base_q <= '0;
      col_base_q  <= '0;
`ifdef LCD_CHAR_INVERT_EN
      invert_q    <= 1'b0;
`endif
    end else if (accept) begin
      page_base_q <= page_base;
      col_base_q  <= col_base;
`ifdef LCD_CHAR_INVERT_EN
      invert_q    <= invert;
`endif
    end
  end

  // Byte as it will be presented to the LCD stage
  always_comb begin
`ifdef LCD_CHAR_INVERT_EN
    cap_data = invert_q ? ~bus.rom_data : bus.rom_data;
`else
    cap_data = bus.rom_data;
`endif
  end

  // LCD output registers: loaded in CAP, frozen through PUSH until the handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q  <= '0;
      page_q  <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
    end else if (capture) begin
      data_q  <= cap_data;
      page_q  <= pos_page;
      col_q   <= pos_col;
      valid_q <= 1'b1;
    end else if (state_q == StPush && bus.lcd_ready) begin
      valid_q <= 1'b0;
    end
  end

  // char_ready spans REQ..PUSH so the combiner keeps this block selected across bytes
  always_comb begin
    busy           = (state_q != StIdle);
    done           = (state_q == StDone);
    bus.char_ready = (state_q == StReq) || (state_q == StCap) || (state_q == StPush);
    bus.rom_addr   = bus.char_ready ? idx_q : '0;
    bus.lcd_valid  = valid_q;
    bus.lcd_data   = data_q;
    bus.lcd_page   = page_q;
    bus.lcd_col    = col_q;
  end

endmodule
